// File: rtl/irq_vector_ctrl.sv
// Interrupt vector controller for up to 16 sources: captures requests into PENDING, masks them,
// and presents a registered combined interrupt plus a fixed-priority (lowest index wins) vector.
module irq_vector_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq_out,
  output logic [3:0]       irq_id
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;

  // Bits at or above N_IRQ are held at zero in every 16-bit register.
  localparam logic [15:0] VALID_MASK = 16'((32'd1 << N_IRQ) - 32'd1);

  function automatic logic [15:0] zext_irq(input logic [N_IRQ-1:0] v);
    logic [15:0] r;
    r = 16'h0000;
    r[N_IRQ-1:0] = v;
    return r;
  endfunction

  function automatic logic [3:0] prio_id(input logic [15:0] v);
    logic [3:0] id;
    id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        id = 4'(i);
      end
    end
    return id;
  endfunction

  logic [15:0] pending_r;
  logic [15:0] mask_r;
  logic [15:0] edge_r;
  logic [15:0] irq_d_r;

  logic        wr_s;
  logic [15:0] wdata_s;
  logic [15:0] irq_ext_s;
  logic [15:0] clr_s;
  logic [15:0] force_s;
  logic [15:0] set_s;
  logic [15:0] pending_nxt_s;
  logic [15:0] active_s;
  logic        any_active_s;
  logic [3:0]  vec_id_s;
  logic [15:0] rd_mux_s;

  // Decode writes, build set/clear terms, priority and the read mux.
  always_comb begin
    wr_s          = chipselect && !write_n;
    wdata_s       = writedata & VALID_MASK;
    irq_ext_s     = zext_irq(irq_in);
    clr_s         = 16'h0000;
    force_s       = 16'h0000;
    rd_mux_s      = 16'h0000;

    if (wr_s && (address == ADDR_PENDING)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = 16'h0000;
    end

    if (wr_s && (address == ADDR_FORCE)) begin
      force_s = wdata_s;
    end else begin
      force_s = 16'h0000;
    end

    // Set beats clear, so a source still requesting survives its own W1C.
    set_s         = (edge_r & irq_ext_s & ~irq_d_r) | (~edge_r & irq_ext_s) | force_s;
    pending_nxt_s = ((pending_r & ~clr_s) | set_s) & VALID_MASK;

    active_s      = pending_r & mask_r;
    any_active_s  = |active_s;
    vec_id_s      = prio_id(active_s);

    case (address)
      ADDR_PENDING: rd_mux_s = pending_r;
      ADDR_MASK:    rd_mux_s = mask_r;
      ADDR_EDGE:    rd_mux_s = edge_r;
      ADDR_ACTIVE:  rd_mux_s = active_s;
      ADDR_VECTOR:  rd_mux_s = {any_active_s, 11'd0, vec_id_s};
      ADDR_FORCE:   rd_mux_s = 16'h0000;
      default:      rd_mux_s = 16'h0000;
    endcase
  end

  // Software-owned configuration registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_r <= 16'h0000;
      edge_r <= 16'h0000;
    end else begin
      if (wr_s && (address == ADDR_MASK)) begin
        mask_r <= wdata_s;
      end
      if (wr_s && (address == ADDR_EDGE)) begin
        edge_r <= wdata_s;
      end
    end
  end

  // Request capture; irq_d resets high so a line held across reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_r <= 16'h0000;
      irq_d_r   <= VALID_MASK;
    end else begin
      pending_r <= pending_nxt_s;
      irq_d_r   <= irq_ext_s;
    end
  end

  // Registered bus read data and CPU-facing interrupt outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= 16'h0000;
      irq_out  <= 1'b0;
      irq_id   <= 4'd0;
    end else begin
      readdata <= rd_mux_s;
      irq_out  <= any_active_s;
      irq_id   <= vec_id_s;
    end
  end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl: stimulus pushes expectations into a scoreboard,
// a negedge monitor pops and compares them at their scheduled cycle.
module tb_irq_vector_ctrl;

  localparam int N_IRQ = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [15:0]      writedata;
  logic [15:0]      readdata;
  logic [N_IRQ-1:0] irq_in;
  logic             irq_out;
  logic [3:0]       irq_id;

  irq_vector_ctrl #(.N_IRQ(N_IRQ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: kind 0 = readdata, 1 = irq_out, 2 = irq_id.
  int          q_kind[$];
  logic [15:0] q_exp[$];
  int          q_cyc[$];
  string       q_name[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_kind;
  logic [15:0] m_exp;
  int          m_cyc;
  string       m_name;
  logic [15:0] m_act;

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      m_kind = q_kind.pop_front();
      m_exp  = q_exp.pop_front();
      m_cyc  = q_cyc.pop_front();
      m_name = q_name.pop_front();
      case (m_kind)
        0:       m_act = readdata;
        1:       m_act = {15'd0, irq_out};
        default: m_act = {12'd0, irq_id};
      endcase
      n_checks++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (scheduled cycle %0d, now %0d)",
                 m_name, m_act, m_exp, m_cyc, cyc);
      end
    end
  end

  task automatic expect_at(input int kind, input logic [15:0] exp, input string name, input int at);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_cyc.push_back(at);
    q_name.push_back(name);
  endtask

  task automatic chk_irq(input logic o, input logic [3:0] id, input string name, input int at);
    expect_at(1, {15'd0, o}, {name, "_out"}, at);
    expect_at(2, {12'd0, id}, {name, "_id"}, at);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    address = a;
    expect_at(0, exp, name, cyc + 1);
    step(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    irq_in     = 8'h01;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 16'h0000;
    step(3);
    expect_at(0, 16'h0000, "reset_readdata", cyc);
    chk_irq(1'b0, 4'd0, "reset", cyc);
    reset_n = 1'b1;

    // Bit 0 held high across reset; switch to edge mode and clear the level capture.
    wr(3'd2, 16'h0001);
    wr(3'd0, 16'h0001);
    wr(3'd1, 16'h0001);
    chk_irq(1'b0, 4'd0, "edge_no_spurious", cyc + 1);
    rd(3'd0, 16'h0000, "edge_pending_held");
    step(2);
    chk_irq(1'b0, 4'd0, "edge_still_quiet", cyc);
    irq_in = 8'h00;
    step(1);
    irq_in = 8'h01;
    chk_irq(1'b0, 4'd0, "edge_lat_E", cyc + 1);
    chk_irq(1'b1, 4'd0, "edge_lat_E1", cyc + 2);
    step(1);
    rd(3'd0, 16'h0001, "edge_pending_set");

    // Level mode: W1C while input high keeps the bit.
    wr(3'd2, 16'h0000);
    wr(3'd0, 16'h0001);
    rd(3'd0, 16'h0001, "level_w1c_held");
    chk_irq(1'b1, 4'd0, "level_irq_held", cyc);
    irq_in = 8'h00;
    wr(3'd0, 16'h0001);
    chk_irq(1'b1, 4'd0, "level_clr_E", cyc);
    chk_irq(1'b0, 4'd0, "level_clr_E1", cyc + 1);
    step(1);

    // Priority.
    wr(3'd5, 16'h0028);
    wr(3'd1, 16'h00FF);
    chk_irq(1'b1, 4'd3, "prio_id3", cyc + 1);
    rd(3'd4, 16'h8003, "prio_vector3");
    rd(3'd5, 16'h0000, "force_reads_zero");
    wr(3'd0, 16'h0008);
    chk_irq(1'b1, 4'd5, "prio_id5", cyc + 1);
    wr(3'd0, 16'h0020);
    chk_irq(1'b0, 4'd0, "prio_none", cyc + 1);
    rd(3'd4, 16'h0000, "prio_vector0");

    // Masking.
    wr(3'd1, 16'h0000);
    wr(3'd5, 16'h0004);
    step(1);
    rd(3'd3, 16'h0000, "mask_active0");
    chk_irq(1'b0, 4'd0, "mask_irq0", cyc);
    rd(3'd0, 16'h0004, "mask_pending");
    wr(3'd1, 16'h0004);
    chk_irq(1'b0, 4'd0, "mask_E", cyc);
    chk_irq(1'b1, 4'd2, "mask_E1", cyc + 1);
    step(1);

    // Edge-mode rising edge coincident with W1C on the same bit.
    wr(3'd2, 16'h0002);
    irq_in = 8'h02;
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0006, "collide_pending");
    wr(3'd1, 16'hFFFF);
    rd(3'd1, 16'h00FF, "mask_upper_ignored");
    chk_irq(1'b1, 4'd1, "collide_id1", cyc);

    // Reset mid-operation.
    irq_in  = 8'h00;
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    expect_at(0, 16'h0000, "rst_readdata", cyc);
    chk_irq(1'b0, 4'd0, "rst", cyc);
    rd(3'd0, 16'h0000, "rst_pending");
    rd(3'd1, 16'h0000, "rst_mask");
    rd(3'd2, 16'h0000, "rst_edge");
    chk_irq(1'b0, 4'd0, "rst_after", cyc);

    for (int i = 0; i < 20 && q_cyc.size() > 0; i++) begin
      step(1);
    end
    if (q_cyc.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q_cyc.size());
      $fatal(1, "scoreboard did not drain");
    end
    step(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
